// File: rtl/sensor_drain_seq.sv
// sensor_drain_seq: waits for the sensor buffer to fill, copies every word
// into a destination buffer over a valid/ready write port, keeps a running
// checksum, then pulses a clear to the sensor controller and reports
// completion.
module sensor_drain_seq #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic          cfg_auto,
  input  logic          cfg_abort,
  input  logic [31:0]   cfg_base,
  input  logic          irq_clr,
  output logic          sctrl_en,
  output logic          sctrl_clear,
  output logic [AW-1:0] sctrl_addr,
  input  logic          sctrl_interrupt,
  input  logic [31:0]   sctrl_out,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic          busy,
  output logic          done_irq,
  output logic [31:0]   checksum,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_base;
  logic [31:0]   r_checksum;
  logic [15:0]   r_frame_cnt;
  logic          r_done_irq;
  logic          r_abort;      // remembers that CLEAR was reached by abort

  logic w_xfer;
  logic w_last;
  logic w_abort_now;
  logic w_start_frame;

  assign w_xfer        = (r_state == DRAIN) && wr_ready;
  assign w_last        = (r_idx == AW'(DEPTH - 1));
  assign w_abort_now   = cfg_abort && ((r_state == FILL) || (r_state == DRAIN));
  // A new frame begins from IDLE on start, or straight out of DONE in auto mode.
  assign w_start_frame = ((r_state == IDLE) && cfg_start) ||
                         ((r_state == DONE) && cfg_auto);

  // State register; reset abandons any frame without visiting CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and state-driven outputs.
  always_comb begin
    w_next_state = r_state;
    sctrl_en     = 1'b0;
    sctrl_clear  = 1'b0;
    sctrl_addr   = '0;
    wr_valid     = 1'b0;
    wr_addr      = 32'd0;
    wr_data      = 32'd0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (cfg_start) w_next_state = FILL;
      end
      FILL: begin
        sctrl_en = 1'b1;
        if (cfg_abort)            w_next_state = CLEAR;
        else if (sctrl_interrupt) w_next_state = DRAIN;
      end
      DRAIN: begin
        sctrl_addr = r_idx;
        wr_valid   = 1'b1;
        // Address and data are pure functions of r_idx, so they hold while stalled.
        wr_addr    = r_base + (32'(r_idx) << 2);
        wr_data    = sctrl_out;
        if (cfg_abort)            w_next_state = CLEAR;
        else if (wr_ready && w_last) w_next_state = CLEAR;
      end
      CLEAR: begin
        sctrl_clear  = 1'b1;
        w_next_state = r_abort ? IDLE : DONE;
      end
      DONE: begin
        w_next_state = cfg_auto ? FILL : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Frame datapath: base latch, drain index, checksum, counters and irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_base      <= 32'd0;
      r_checksum  <= 32'd0;
      r_frame_cnt <= 16'd0;
      r_done_irq  <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      if (w_start_frame) begin
        r_base     <= cfg_base;
        r_idx      <= '0;
        r_checksum <= 32'd0;
      end else if (w_xfer) begin
        // A word moving in the abort cycle still counts.
        r_checksum <= r_checksum + sctrl_out;
        r_idx      <= r_idx + AW'(1);
      end

      if (w_abort_now)            r_abort <= 1'b1;
      else if (r_state == CLEAR)  r_abort <= 1'b0;

      if (r_state == DONE) r_frame_cnt <= r_frame_cnt + 16'd1;

      // Setting in DONE takes priority over a simultaneous clear.
      if (r_state == DONE) r_done_irq <= 1'b1;
      else if (irq_clr)    r_done_irq <= 1'b0;
    end
  end

  assign done_irq  = r_done_irq;
  assign checksum  = r_checksum;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_sensor_drain_seq.sv
// Testbench for sensor_drain_seq: scoreboard of expected destination writes
// plus per-scenario tasks with inline checks.
module tb_sensor_drain_seq;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cfg_start, cfg_auto, cfg_abort, irq_clr;
  logic [31:0]   cfg_base;
  logic          sctrl_en, sctrl_clear, sctrl_interrupt;
  logic [AW-1:0] sctrl_addr;
  logic [31:0]   sctrl_out;
  logic          wr_valid, wr_ready;
  logic [31:0]   wr_addr, wr_data;
  logic          busy, done_irq;
  logic [31:0]   checksum;
  logic [15:0]   frame_cnt;

  logic [31:0] sensor_mem [DEPTH];
  assign sctrl_out = sensor_mem[sctrl_addr];

  sensor_drain_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_auto(cfg_auto),
    .cfg_abort(cfg_abort), .cfg_base(cfg_base), .irq_clr(irq_clr),
    .sctrl_en(sctrl_en), .sctrl_clear(sctrl_clear), .sctrl_addr(sctrl_addr),
    .sctrl_interrupt(sctrl_interrupt), .sctrl_out(sctrl_out),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done_irq(done_irq),
    .checksum(checksum), .frame_cnt(frame_cnt)
  );

  logic [63:0] exp_q [$];
  int n_checks = 0;
  int n_pass = 0;
  int xfer_count = 0;
  int clr_count = 0;
  int n_stalls = 0;
  logic        stalled_prev = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] prev_data = 32'd0;

  // Scoreboard monitor: one line per accepted write, checks stall stability.
  always @(negedge clk) begin
    logic [63:0] e;
    if (sctrl_clear) clr_count++;
    if (!rst && wr_valid) begin
      if (stalled_prev) begin
        n_stalls++;
        n_checks++;
        if (wr_addr !== prev_addr || wr_data !== prev_data)
          $display("FAIL stall_stable: got %h/%h expected %h/%h", wr_addr, wr_data, prev_addr, prev_data);
        else n_pass++;
      end
      if (wr_ready) begin
        xfer_count++;
        stalled_prev = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: got %h/%h expected none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e)
            $display("FAIL write: got %h/%h expected %h/%h", wr_addr, wr_data, e[63:32], e[31:0]);
          else begin
            n_pass++;
            $display("write addr=%h data=%h ok", wr_addr, wr_data);
          end
        end
      end else begin
        stalled_prev = 1'b1;
        prev_addr    = wr_addr;
        prev_data    = wr_data;
      end
    end else begin
      stalled_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill sensor buffer (mode 0: 1..DEPTH, else random), queue the first nwords writes.
  task automatic load_frame(input logic [31:0] base, input int mode, input int nwords,
                            output logic [31:0] sum);
    sum = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      sensor_mem[i] = (mode == 0) ? 32'(i + 1) : $urandom;
      if (i < nwords) begin
        exp_q.push_back({base + 32'(4 * i), sensor_mem[i]});
        sum = sum + sensor_mem[i];
      end
    end
  endtask

  task automatic start_frame(input logic [31:0] base);
    cfg_base  = base;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic fill_to_drain();
    tick();
    sctrl_interrupt = 1'b1;
    tick();
    sctrl_interrupt = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit toggle, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (toggle) wr_ready = ~wr_ready;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_clear(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sctrl_clear) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 0; cfg_auto = 0; cfg_abort = 0; irq_clr = 0;
    cfg_base = 32'hDEAD_BEEF; sctrl_interrupt = 0; wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) sensor_mem[i] = 32'd0;
    tick(); tick();
    n_checks++;
    if ({busy, done_irq, sctrl_en, sctrl_clear, wr_valid} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done_irq, sctrl_en, sctrl_clear, wr_valid});
    else n_pass++;
    n_checks++;
    if ({checksum, frame_cnt, wr_addr, wr_data, sctrl_addr} !== '0)
      $display("FAIL reset_data: got %h/%h/%h/%h expected zero", checksum, frame_cnt, wr_addr, wr_data);
    else n_pass++;
    rst = 1'b0;
    tick();
    $display("reset done");
  endtask

  task automatic test_single_frame();
    logic [31:0] sum;
    bit to;
    xfer_count = 0; clr_count = 0;
    load_frame(32'h1000, 0, DEPTH, sum);
    start_frame(32'h1000);
    fill_to_drain();
    wait_idle(300, 1'b0, to);
    n_checks++; if (to) $display("FAIL single_timeout: got busy expected idle"); else n_pass++;
    n_checks++; if (xfer_count != 64) $display("FAIL single_xfers: got %0d expected 64", xfer_count); else n_pass++;
    n_checks++; if (checksum !== 32'd2080) $display("FAIL single_checksum: got %0d expected 2080", checksum); else n_pass++;
    n_checks++; if (clr_count != 1) $display("FAIL single_clear: got %0d expected 1", clr_count); else n_pass++;
    n_checks++; if (done_irq !== 1'b1) $display("FAIL single_irq: got %b expected 1", done_irq); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd1) $display("FAIL single_frames: got %0d expected 1", frame_cnt); else n_pass++;
    $display("single frame done checksum=%0d", checksum);
  endtask

  task automatic test_irq_collision();
    logic [31:0] sum;
    bit to;
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    n_checks++; if (done_irq !== 1'b0) $display("FAIL irq_clear: got %b expected 0", done_irq); else n_pass++;
    load_frame(32'h2000, 1, DEPTH, sum);
    start_frame(32'h2000);
    fill_to_drain();
    wait_clear(300, to);
    n_checks++; if (to) $display("FAIL coll_timeout: got no clear expected clear"); else n_pass++;
    @(posedge clk); #1;
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    n_checks++; if (done_irq !== 1'b1) $display("FAIL coll_set_wins: got %b expected 1", done_irq); else n_pass++;
    n_checks++; if (checksum !== sum) $display("FAIL coll_checksum: got %h expected %h", checksum, sum); else n_pass++;
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    n_checks++; if (done_irq !== 1'b0) $display("FAIL coll_clear_after: got %b expected 0", done_irq); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd2 || busy !== 1'b0) $display("FAIL coll_frames: got %0d/%b expected 2/0", frame_cnt, busy); else n_pass++;
    $display("irq collision done");
  endtask

  task automatic test_backpressure();
    logic [31:0] sum;
    bit to;
    int stalls0;
    xfer_count = 0; clr_count = 0; stalls0 = n_stalls;
    load_frame(32'h3000, 0, DEPTH, sum);
    start_frame(32'h3000);
    fill_to_drain();
    wait_idle(400, 1'b1, to);
    wr_ready = 1'b1;
    n_checks++; if (to) $display("FAIL bp_timeout: got busy expected idle"); else n_pass++;
    n_checks++; if (xfer_count != 64) $display("FAIL bp_xfers: got %0d expected 64", xfer_count); else n_pass++;
    n_checks++; if (checksum !== 32'd2080) $display("FAIL bp_checksum: got %0d expected 2080", checksum); else n_pass++;
    n_checks++; if (n_stalls - stalls0 < 32) $display("FAIL bp_stalls: got %0d expected >=32", n_stalls - stalls0); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd3) $display("FAIL bp_frames: got %0d expected 3", frame_cnt); else n_pass++;
    $display("backpressure done stalls=%0d", n_stalls - stalls0);
  endtask

  task automatic test_abort();
    logic [31:0] sum;
    bit to;
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    xfer_count = 0; clr_count = 0;
    load_frame(32'h4000, 1, 11, sum);
    start_frame(32'h4000);
    fill_to_drain();
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_valid && sctrl_addr == AW'(10)) begin
        to = 1'b0;
        break;
      end
    end
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    n_checks++; if (to) $display("FAIL abort_reach: got no idx10 expected idx10"); else n_pass++;
    wait_idle(10, 1'b0, to);
    n_checks++; if (to || busy !== 1'b0) $display("FAIL abort_idle: got busy=%b expected 0", busy); else n_pass++;
    n_checks++; if (clr_count != 1) $display("FAIL abort_clear: got %0d expected 1", clr_count); else n_pass++;
    n_checks++; if (done_irq !== 1'b0) $display("FAIL abort_irq: got %b expected 0", done_irq); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd3) $display("FAIL abort_frames: got %0d expected 3", frame_cnt); else n_pass++;
    n_checks++; if (xfer_count != 11 || checksum !== sum) $display("FAIL abort_sum: got %0d/%h expected 11/%h", xfer_count, checksum, sum); else n_pass++;
    $display("abort done");
  endtask

  task automatic test_auto();
    logic [31:0] sum;
    logic [31:0] next_sum;
    bit to;
    cfg_auto = 1'b1;
    load_frame(32'h8000, 1, DEPTH, sum);
    start_frame(32'h8000);
    for (int k = 0; k < 3; k++) begin
      fill_to_drain();
      wait_clear(300, to);
      n_checks++; if (to) $display("FAIL auto_timeout%0d: got no clear expected clear", k); else n_pass++;
      n_checks++; if (checksum !== sum) $display("FAIL auto_checksum%0d: got %h expected %h", k, checksum, sum); else n_pass++;
      if (k < 2) begin
        load_frame(32'h8000 + 32'(k + 1) * 32'h400, 1, DEPTH, next_sum);
        cfg_base = 32'h8000 + 32'(k + 1) * 32'h400;
        sum = next_sum;
      end else begin
        cfg_auto = 1'b0;
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (k < 2) begin
        n_checks++;
        if (sctrl_en !== 1'b1 || checksum !== 32'd0)
          $display("FAIL auto_refill%0d: got en=%b sum=%h expected 1/0", k, sctrl_en, checksum);
        else n_pass++;
      end
    end
    n_checks++; if (busy !== 1'b0 || frame_cnt !== 16'd6) $display("FAIL auto_frames: got %0d/%b expected 6/0", frame_cnt, busy); else n_pass++;
    $display("auto mode done frames=%0d", frame_cnt);
  endtask

  task automatic test_midframe_reset();
    logic [31:0] sum;
    bit to;
    load_frame(32'h5000, 1, 30, sum);
    start_frame(32'h5000);
    fill_to_drain();
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_valid && sctrl_addr == AW'(29)) begin
        to = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    clr_count = 0;
    rst = 1'b1;
    tick();
    n_checks++; if (to) $display("FAIL rst_reach: got no idx29 expected idx29"); else n_pass++;
    n_checks++;
    if ({busy, done_irq, sctrl_en, sctrl_clear, wr_valid, checksum, frame_cnt, wr_addr, wr_data, sctrl_addr} !== '0)
      $display("FAIL rst_outputs: got busy=%b sum=%h cnt=%0d addr=%h expected zero", busy, checksum, frame_cnt, wr_addr);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick(); tick();
    n_checks++; if (clr_count != 0 || exp_q.size() != 0) $display("FAIL rst_noclear: got %0d/%0d expected 0/0", clr_count, exp_q.size()); else n_pass++;
    xfer_count = 0;
    load_frame(32'h6000, 1, DEPTH, sum);
    start_frame(32'h6000);
    fill_to_drain();
    wait_idle(300, 1'b0, to);
    n_checks++; if (to || xfer_count != 64) $display("FAIL rst_refresh: got %0d expected 64", xfer_count); else n_pass++;
    n_checks++; if (checksum !== sum || frame_cnt !== 16'd1) $display("FAIL rst_refresh_sum: got %h/%0d expected %h/1", checksum, frame_cnt, sum); else n_pass++;
    $display("midframe reset done");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_irq_collision();
    test_backpressure();
    test_abort();
    test_auto();
    test_midframe_reset();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL leftover_writes: got %0d expected 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sensor_drain_seq.md
SENSOR_DRAIN_SEQ -- requirements
Module: sensor_drain_seq

Interface
REQ-001 Parameters SHALL be: DEPTH, default 64, number of words per sensor frame; AW, default 6, sensor buffer address width (DEPTH = 2**AW).
REQ-002 Port clk, input, 1: clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port cfg_start, input, 1: single-cycle pulse that starts one frame capture; honoured only in IDLE.
REQ-005 Port cfg_auto, input, 1: when 1, capture restarts automatically after each frame.
REQ-006 Port cfg_abort, input, 1: cancels the current frame.
REQ-007 Port cfg_base, input, 32: byte base address of the destination buffer; sampled on leaving IDLE.
REQ-008 Port irq_clr, input, 1: clears done_irq.
REQ-009 Port sctrl_en, output, 1: enable to the sensor controller.
REQ-010 Port sctrl_clear, output, 1: clear pulse to the sensor controller.
REQ-011 Port sctrl_addr, output, AW: read address into the sensor buffer.
REQ-012 Port sctrl_interrupt, input, 1: sensor buffer full.
REQ-013 Port sctrl_out, input, 32: buffer word, combinational from sctrl_addr.
REQ-014 Ports wr_valid (output, 1), wr_ready (input, 1), wr_addr (output, 32), wr_data (output, 32): destination memory write port.
REQ-015 Ports busy (output, 1), done_irq (output, 1), checksum (output, 32), frame_cnt (output, 16): status outputs.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, FILL, DRAIN, CLEAR and DONE.
REQ-017 IDLE: all control outputs 0; on cfg_start go to FILL, latching base_q = cfg_base, resetting the drain index to 0 and checksum to 0.
REQ-018 FILL: sctrl_en = 1; on sctrl_interrupt = 1 go to DRAIN on the next cycle.
REQ-019 DRAIN: sctrl_en = 0, sctrl_addr = idx, wr_valid = 1, wr_data = sctrl_out, and wr_addr = base_q + 4*idx (32-bit, wraps modulo 2**32).
REQ-020 DRAIN handshake: a word transfers only in a cycle with wr_valid && wr_ready; wr_addr and wr_data SHALL stay stable while wr_ready = 0.
REQ-021 On each transfer, checksum SHALL add wr_data modulo 2**32 and idx SHALL increment; a transfer at idx = DEPTH-1 goes to CLEAR and idx wraps to 0.
REQ-022 CLEAR: sctrl_clear = 1 for exactly one cycle with sctrl_en = 0, then go to DONE (normal path) or IDLE (abort path).
REQ-023 DONE (one cycle): done_irq is set, frame_cnt increments (wrapping 0xFFFF to 0), then go to FILL if cfg_auto = 1 (base_q re-sampled, checksum and idx reset), else to IDLE.
REQ-024 done_irq SHALL be sticky until an irq_clr cycle; if set and irq_clr occur in the same cycle, the set wins.
REQ-025 cfg_abort in FILL or DRAIN SHALL go to CLEAR without setting done_irq and without incrementing frame_cnt; a word transferring in the abort cycle still counts toward checksum.
REQ-026 cfg_abort SHALL be ignored in IDLE, CLEAR and DONE; cfg_start SHALL be ignored outside IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 checksum SHALL hold its value after a frame until the next FILL entry.

Reset
REQ-029 While rst = 1, the FSM SHALL be in IDLE and all outputs, idx, base_q, checksum, frame_cnt and done_irq SHALL be 0.
REQ-030 rst asserted in any state SHALL abandon the frame immediately with no sctrl_clear pulse; rst has priority over all other inputs.

Verification
REQ-031 Single frame: base 0x1000, wr_ready = 1, sensor fills words 1..64 -> 64 writes at 0x1000..0x10FC, checksum = 2080, one sctrl_clear pulse, done_irq = 1, frame_cnt = 1, then IDLE.
REQ-032 Backpressure: wr_ready toggles every cycle -> wr_addr and wr_data stay stable while stalled, exactly 64 transfers, same checksum as the unstalled run.
REQ-033 Abort: cfg_abort at idx = 10 in DRAIN -> one sctrl_clear pulse, done_irq = 0, frame_cnt unchanged, IDLE, busy = 0.
REQ-034 Auto mode: cfg_auto = 1 across 3 frames -> frame_cnt = 3, FILL re-entered after each DONE, checksum reset per frame.
REQ-035 Set/clear collision: irq_clr asserted in the DONE cycle -> done_irq = 1; irq_clr one cycle later -> done_irq = 0.
REQ-036 Mid-frame reset: rst during DRAIN at idx = 30 -> next cycle all outputs 0, no sctrl_clear, and a fresh cfg_start runs a full 64-word frame.
